// File: rtl/power_unit_if.sv
// Handshake bundle for power_unit: start/d/e request side, busy/done/q/overflow result side.
// Latency: n/a (wires only).
// Backpressure: none; the master must watch busy, and a start raised while busy is dropped.
interface power_unit_if #(
   parameter int N  = 4,
   parameter int M  = N * 2,
   parameter int EW = 4
);
   logic          start;
   logic [N-1:0]  d;
   logic [EW-1:0] e;
   logic          busy;
   logic          done;
   logic [M-1:0]  q;
   logic          overflow;

   modport master (
      output start, d, e,
      input  busy, done, q, overflow
   );

   modport slave (
      input  start, d, e,
      output busy, done, q, overflow
   );
endinterface

// File: rtl/power_unit.sv
// Iterative unsigned power q = d**e using right-to-left square-and-multiply, one exponent bit per clock.
// Latency: bitlen(e)+1 cycles from the start edge to done (1 for e=0, EW+1 for e=2**EW-1).
// Backpressure: start is only accepted in IDLE (including the done cycle); POWER_UNIT_SATURATE_EN clamps q to all ones on overflow.
module power_unit #(
   parameter int N  = 4,
   parameter int M  = N * 2,
   parameter int EW = 4
) (
   input logic         clock,
   input logic         reset,
   power_unit_if.slave bus
);

   // The result register must be able to hold the zero-extended base.
   if (M < N) begin : g_width_check
      $error("power_unit: M must be >= N");
   end

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state;
   logic [M-1:0]  res;
   logic [M-1:0]  base;
   logic [EW-1:0] exp;
   logic          res_ovf;
   logic          base_ovf;

   logic [2*M-1:0] mul_prod;
   logic [2*M-1:0] sq_prod;
   logic           mul_hi;
   logic           sq_hi;
   logic [M-1:0]   final_q;

   // Full-width products; any set upper half means the true value no longer fits in M bits.
   always_comb begin
      mul_prod = {{M{1'b0}}, res} * {{M{1'b0}}, base};
      sq_prod  = {{M{1'b0}}, base} * {{M{1'b0}}, base};
      mul_hi   = |mul_prod[2*M-1:M];
      sq_hi    = |sq_prod[2*M-1:M];
   end

   // Value presented on q at done: truncated, or clamped when saturation is built in.
   always_comb begin
`ifdef POWER_UNIT_SATURATE_EN
      final_q = res_ovf ? {M{1'b1}} : res;
`else
      final_q = res;
`endif
   end

   // Control FSM and datapath; an overflowed square only matters once it is multiplied into res.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         res          <= '0;
         base         <= '0;
         exp          <= '0;
         res_ovf      <= 1'b0;
         base_ovf     <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.q        <= '0;
         bus.overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  res      <= {{(M-1){1'b0}}, 1'b1};
                  base     <= M'(bus.d);
                  exp      <= bus.e;
                  res_ovf  <= 1'b0;
                  base_ovf <= 1'b0;
                  bus.busy <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (exp == '0) begin
                  bus.q        <= final_q;
                  bus.overflow <= res_ovf;
                  bus.done     <= 1'b1;
                  bus.busy     <= 1'b0;
                  state        <= IDLE;
               end else begin
                  if (exp[0]) begin
                     res     <= mul_prod[M-1:0];
                     res_ovf <= res_ovf | mul_hi | base_ovf;
                  end
                  base     <= sq_prod[M-1:0];
                  base_ovf <= base_ovf | sq_hi;
                  exp      <= exp >> 1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_power_unit.sv
// Self-checking bench for power_unit (N=4, M=8, EW=4).
// Directed table, hand-written handshake/reset sequences, then random operations vs an exact-arithmetic model.
// Honours POWER_UNIT_SATURATE_EN when computing expected q.
module tb_power_unit;

   localparam int N  = 4;
   localparam int M  = 8;
   localparam int EW = 4;

`ifdef POWER_UNIT_SATURATE_EN
   localparam logic [7:0] Q_15_3 = 8'd255;
   localparam logic [7:0] Q_4_4  = 8'd255;
`else
   localparam logic [7:0] Q_15_3 = 8'd47;
   localparam logic [7:0] Q_4_4  = 8'd0;
`endif

   logic clock;
   logic reset;
   int   checks;
   int   errors;
   logic [7:0] last_q;

   power_unit_if #(.N(N), .M(M), .EW(EW)) bus ();

   power_unit #(.N(N), .M(M), .EW(EW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [3:0] d;
      logic [3:0] e;
      logic [7:0] q;
      logic       ovf;
      int         lat;
   } vec_t;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: exact power in 64-bit arithmetic (15**15 < 2**64).
   function automatic void model(input int dv, input int ev,
                                 output logic [7:0] qv, output logic ov, output int lat);
      longint unsigned p;
      p = 1;
      for (int i = 0; i < ev; i++) p = p * longint'(dv);
      ov = (p >= 256);
`ifdef POWER_UNIT_SATURATE_EN
      qv = ov ? 8'hFF : p[7:0];
`else
      qv = p[7:0];
`endif
      lat = $clog2(ev + 1) + 1;
   endfunction

   // Issue one operation from an IDLE cycle; returns done offset from the start edge.
   task automatic run_op(input logic [3:0] dv, input logic [3:0] ev, input bit poke,
                         output int lat, output int busy_cnt,
                         output logic [7:0] qv, output logic ov);
      bus.start = 1'b1;
      bus.d     = dv;
      bus.e     = ev;
      @(posedge clock); #1;
      bus.start = 1'b0;
      bus.d     = 4'($urandom);
      bus.e     = 4'($urandom);
      lat = -1;
      busy_cnt = 0;
      check("q_hold", bus.q, last_q);
      for (int c = 0; c < 40; c++) begin
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            lat = c;
            break;
         end
         if (poke && c == 1) begin
            bus.start = 1'b1;
            bus.d     = 4'd9;
            bus.e     = 4'd9;
         end else if (poke && c == 2) begin
            bus.start = 1'b0;
         end
         @(posedge clock); #1;
      end
      bus.start = 1'b0;
      if (lat < 0) begin
         errors++;
         $display("FAIL done_timeout: no done for d=%0d e=%0d", dv, ev);
      end
      qv = bus.q;
      ov = bus.overflow;
      last_q = qv;
   endtask

   vec_t vecs[9];

   initial begin
      int lat, bc, n_done, prev_done;
      logic [7:0] qv, eq;
      logic ov, eov;
      int elat;

      checks = 0;
      errors = 0;
      last_q = 8'd0;
      bus.start = 1'b0;
      bus.d = '0;
      bus.e = '0;
      reset = 1'b1;

      vecs[0] = '{d:4'd3,  e:4'd4,  q:8'd81,  ovf:1'b0, lat:4};
      vecs[1] = '{d:4'd0,  e:4'd0,  q:8'd1,   ovf:1'b0, lat:1};
      vecs[2] = '{d:4'd0,  e:4'd5,  q:8'd0,   ovf:1'b0, lat:4};
      vecs[3] = '{d:4'd15, e:4'd3,  q:Q_15_3, ovf:1'b1, lat:3};
      vecs[4] = '{d:4'd2,  e:4'd7,  q:8'd128, ovf:1'b0, lat:4};
      vecs[5] = '{d:4'd1,  e:4'd15, q:8'd1,   ovf:1'b0, lat:5};
      vecs[6] = '{d:4'd5,  e:4'd3,  q:8'd125, ovf:1'b0, lat:3};
      vecs[7] = '{d:4'd4,  e:4'd4,  q:Q_4_4,  ovf:1'b1, lat:4};
      vecs[8] = '{d:4'd7,  e:4'd1,  q:8'd7,   ovf:1'b0, lat:2};

      repeat (3) @(posedge clock);
      #1;
      check("rst_q", bus.q, 0);
      check("rst_done", bus.done, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_ovf", bus.overflow, 0);
      #2 reset = 1'b0;
      @(posedge clock); #1;

      // Directed table
      foreach (vecs[i]) begin
         run_op(vecs[i].d, vecs[i].e, 1'b0, lat, bc, qv, ov);
         check($sformatf("vec%0d_q", i), qv, vecs[i].q);
         check($sformatf("vec%0d_ovf", i), ov, vecs[i].ovf);
         check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
         check($sformatf("vec%0d_busy", i), bc, vecs[i].lat);
         @(posedge clock); #1;
         check($sformatf("vec%0d_done_pulse", i), bus.done, 0);
      end

      // Start pulse mid-RUN must be ignored
      run_op(4'd3, 4'd15, 1'b1, lat, bc, qv, ov);
      model(3, 15, eq, eov, elat);
      check("poke_q", qv, eq);
      check("poke_ovf", ov, eov);
      check("poke_lat", lat, elat);
      @(posedge clock); #1;
      check("poke_no_restart", bus.busy, 0);

      // start held high: back-to-back 2**3, done every 4 cycles
      bus.start = 1'b1;
      bus.d = 4'd2;
      bus.e = 4'd3;
      n_done = 0;
      prev_done = -1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clock); #1;
         if (bus.done) begin
            check("b2b_q", bus.q, 8);
            if (prev_done >= 0) check("b2b_spacing", c - prev_done, 4);
            prev_done = c;
            n_done++;
         end
      end
      bus.start = 1'b0;
      check("b2b_count", n_done, 5);
      repeat (6) @(posedge clock);
      #1;
      last_q = bus.q;

      // Asynchronous reset mid-RUN
      bus.start = 1'b1;
      bus.d = 4'd3;
      bus.e = 4'd15;
      @(posedge clock); #1;
      bus.start = 1'b0;
      @(posedge clock); #1;
      check("pre_rst_busy", bus.busy, 1);
      #2 reset = 1'b1;
      #1;
      check("arst_q", bus.q, 0);
      check("arst_done", bus.done, 0);
      check("arst_busy", bus.busy, 0);
      check("arst_ovf", bus.overflow, 0);
      @(posedge clock);
      #3 reset = 1'b0;
      n_done = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clock); #1;
         if (bus.done || bus.busy) n_done++;
      end
      check("arst_no_done", n_done, 0);
      last_q = 8'd0;
      run_op(4'd3, 4'd4, 1'b0, lat, bc, qv, ov);
      check("post_rst_q", qv, 81);
      check("post_rst_lat", lat, 4);

      // Random operations against the exact model; next start lands in the done cycle
      for (int k = 0; k < 150; k++) begin
         logic [3:0] rd, re;
         rd = 4'($urandom);
         re = 4'($urandom);
         run_op(rd, re, 1'b0, lat, bc, qv, ov);
         model(int'(rd), int'(re), eq, eov, elat);
         check("rnd_q", qv, eq);
         check("rnd_ovf", ov, eov);
         check("rnd_lat", lat, elat);
         check("rnd_busy", bc, elat);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/power_unit.md
Name: power_unit

Overview:
- Iterative unsigned exponentiation unit computing q = d**e, with a runtime exponent `e` rather than an elaboration-time one.
- Uses right-to-left square-and-multiply with a start/busy/done handshake; one exponent bit is consumed per clock.
- Reports overflow of the M-bit result.
- Sits in datapath blocks that need small integer powers without building a fully unrolled multiplier chain.

Parameters:
- N, 4: input operand width `d`.
- M, N*2: result width `q`; M >= N is required (elaboration error otherwise).
- EW, 4: exponent width `e`; maximum exponent is 2**EW-1.

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: request a new operation; sampled only in IDLE.
- d, input, N: base operand, unsigned; captured on an accepted start.
- e, input, EW: exponent, unsigned; captured on an accepted start.
- busy, output, 1: high while an operation is in progress (state RUN).
- done, output, 1: one-cycle pulse when q and overflow are updated.
- q, output, M: result; held until the next done.
- overflow, output, 1: true result >= 2**M; valid with done, held with q.

Behaviour:
- Reset (async assert, sync release): state=IDLE; q=0, done=0, busy=0, overflow=0; internal res/base/exp/flags cleared. Reset mid-operation aborts it with no done pulse.
- Internal registers: res[M], base[M], exp[EW], res_ovf, base_ovf.
- IDLE:
  - done=0 unless it is the pulse cycle.
  - On start=1: res<=1, base<=zero-extended d, exp<=e, res_ovf<=0, base_ovf<=0, busy<=1, go to RUN.
- RUN, exp==0:
  - q<=res; overflow<=res_ovf (or saturation, see Optional Feature).
  - done<=1 for exactly one cycle; busy<=0; go to IDLE.
- RUN, exp!=0:
  - If exp[0]: res<=res*base, truncated to the low M bits of the 2M-bit product; res_ovf<=res_ovf | (upper M product bits != 0) | base_ovf.
  - Always: base<=base*base truncated; base_ovf<=base_ovf | (upper M square bits != 0); exp<=exp>>1.
  - An overflowed square that is never multiplied into res does not set overflow.
- Latency:
  - Start accepted at edge k; done high in the cycle following edge k+L+1, where L = bit length of e (L=0 for e=0).
  - e=0 gives a 1-cycle latency; e=2**EW-1 gives EW+1 cycles.
- 0**0 = 1. 0**e = 0 for e>0, with overflow=0.
- start while busy is ignored (no queuing). start in the done-pulse cycle (state already IDLE) is accepted, so back-to-back operations are possible.
- d and e are don't-care outside the start-acceptance cycle.
- Output q is registered; it changes only on the done edge or on reset.

Optional Feature:
- Macro: POWER_UNIT_SATURATE_EN.
- Defined: when the final res_ovf=1, q<=all ones ({M{1'b1}}) at done; overflow is still asserted.
- Undefined: q<=truncated result (true result mod 2**M); overflow is still asserted.
- The macro has no effect on latency or handshake.

Test Plan:
- Basic power: N=4, M=8, d=3, e=4, start for one cycle → done 4 cycles after the start edge; q=81, overflow=0; busy high for exactly 4 cycles.
- Zero cases: d=0, e=0 → done after 1 cycle, q=1, overflow=0. Then d=0, e=5 → q=0, overflow=0, latency 4.
- Overflow: d=15, e=3 → overflow=1; q=47 without the macro, q=255 with POWER_UNIT_SATURATE_EN. Then d=2, e=7 → q=128, overflow=0 (unused final square of 256 must not flag).
- Handshake: start=1 held continuously with d=2, e=3 → results 8 with done pulses spaced 4 cycles apart (3 busy cycles plus the done cycle); a start pulse mid-RUN with different d/e does not alter the result.
- Reset: assert reset asynchronously mid-RUN of d=3, e=15 → q, done, busy and overflow go to 0 immediately with no clock edge; no done follows. A new start after release yields a correct result.
- Max exponent: d=1, e=15 → latency 5, q=1, overflow=0.
